// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg: CSR addresses, exception codes, trap FSM states and mepc alignment helper
package trap_ctrl_pkg;
  typedef logic [11:0] csr_addr_t;
  localparam csr_addr_t CSR_MSCRATCH = 12'h340;
  localparam csr_addr_t CSR_MEPC     = 12'h341;
  localparam csr_addr_t CSR_MCAUSE   = 12'h342;
  localparam csr_addr_t CSR_MTVAL    = 12'h343;
  localparam logic [31:0] MCAUSE_WARL = 32'h8000_001F;
  typedef enum logic [4:0] {
    INSTR_MISALIGNED = 5'd0,
    INSTR_ACCESS     = 5'd1,
    ILLEGAL_INSN     = 5'd2,
    BREAKPOINT       = 5'd3,
    LOAD_MISALIGNED  = 5'd4,
    LOAD_ACCESS      = 5'd5,
    STORE_MISALIGNED = 5'd6,
    STORE_ACCESS     = 5'd7,
    ECALL_M          = 5'd11
  } exc_cause_t;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    JUMP  = 2'd2
  } trap_state_t;
  function automatic logic [31:0] align_pc(input logic [31:0] pc, input bit isa_c);
    return isa_c ? {pc[31:1], 1'b0} : {pc[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap sequencer owning mepc/mcause/mtval/mscratch; flushes and redirects fetch
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit ISA_C = 1'b0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [4:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic [31:0] mtvec_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_hit_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        busy_o
);
  trap_state_t r_state;
  logic        r_flush, r_rv, r_busy;
  logic [31:0] r_tgt, r_mepc, r_mcause, r_mtval, r_mscratch;
  logic        w_take_exc, w_take_mret;
  logic        w_wr_mscratch, w_wr_mepc, w_wr_mcause, w_wr_mtval;
  always_comb begin
    w_take_exc    = (r_state == IDLE) && exc_valid_i;
    w_take_mret   = (r_state == IDLE) && !exc_valid_i && mret_i;
    w_wr_mscratch = csr_we_i && (csr_addr_i == CSR_MSCRATCH);
    w_wr_mepc     = csr_we_i && (csr_addr_i == CSR_MEPC);
    w_wr_mcause   = csr_we_i && (csr_addr_i == CSR_MCAUSE);
    w_wr_mtval    = csr_we_i && (csr_addr_i == CSR_MTVAL);
  end
  always_comb begin
    csr_hit_o   = (csr_addr_i == CSR_MSCRATCH) || (csr_addr_i == CSR_MEPC) ||
                  (csr_addr_i == CSR_MCAUSE) || (csr_addr_i == CSR_MTVAL);
    csr_rdata_o = (csr_addr_i == CSR_MSCRATCH) ? r_mscratch :
                  (csr_addr_i == CSR_MEPC)     ? r_mepc     :
                  (csr_addr_i == CSR_MCAUSE)   ? r_mcause   :
                  (csr_addr_i == CSR_MTVAL)    ? r_mtval    : '0;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_flush <= 1'b0;
      r_rv    <= 1'b0;
      r_busy  <= 1'b0;
      r_tgt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_take_exc || w_take_mret) begin
            r_state <= FLUSH;
            r_flush <= 1'b1;
            r_busy  <= 1'b1;
            // exceptions ignore vectored mode; mret returns to the pre-write mepc
            r_tgt   <= w_take_exc ? (mtvec_i & 32'hFFFF_FFFC) : r_mepc;
          end
        end
        FLUSH: begin
          r_state <= JUMP;
          r_flush <= 1'b0;
          r_rv    <= 1'b1;
        end
        JUMP: begin
          if (redirect_ready_i) begin
            r_state <= IDLE;
            r_rv    <= 1'b0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_flush <= 1'b0;
          r_rv    <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mepc     <= '0;
      r_mcause   <= '0;
      r_mtval    <= '0;
      r_mscratch <= '0;
    end else begin
      r_mepc     <= w_take_exc  ? align_pc(exc_pc_i, ISA_C) :
                    w_wr_mepc   ? align_pc(csr_wdata_i, ISA_C) : r_mepc;
      r_mcause   <= w_take_exc  ? {27'b0, exc_cause_i} :
                    w_wr_mcause ? (csr_wdata_i & MCAUSE_WARL) : r_mcause;
      r_mtval    <= w_take_exc  ? exc_tval_i :
                    w_wr_mtval  ? csr_wdata_i : r_mtval;
      r_mscratch <= w_wr_mscratch ? csr_wdata_i : r_mscratch;
    end
  end
  assign flush_o          = r_flush;
  assign redirect_valid_o = r_rv;
  assign redirect_pc_o    = r_tgt;
  assign busy_o           = r_busy;
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed stimulus with a cycle-by-cycle behavioural model and literal spot checks
module tb_trap_ctrl;
  logic        clk = 1'b0, rst = 1'b1;
  logic        exc_valid = 1'b0, mret = 1'b0, csr_we = 1'b0, ready = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0, exc_tval = '0, mtvec = '0, csr_wdata = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] rdata0, pc0, rdata1, pc1;
  logic        hit0, flush0, rv0, busy0, hit1, flush1, rv1, busy1;
  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.ISA_C(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .exc_valid_i(exc_valid), .exc_cause_i(exc_cause),
    .exc_pc_i(exc_pc), .exc_tval_i(exc_tval), .mret_i(mret), .mtvec_i(mtvec),
    .csr_addr_i(csr_addr), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(rdata0), .csr_hit_o(hit0), .flush_o(flush0),
    .redirect_valid_o(rv0), .redirect_pc_o(pc0), .redirect_ready_i(ready), .busy_o(busy0));

  trap_ctrl #(.ISA_C(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .exc_valid_i(exc_valid), .exc_cause_i(exc_cause),
    .exc_pc_i(exc_pc), .exc_tval_i(exc_tval), .mret_i(mret), .mtvec_i(mtvec),
    .csr_addr_i(csr_addr), .csr_we_i(csr_we), .csr_wdata_i(csr_wdata),
    .csr_rdata_o(rdata1), .csr_hit_o(hit1), .flush_o(flush1),
    .redirect_valid_o(rv1), .redirect_pc_o(pc1), .redirect_ready_i(ready), .busy_o(busy1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // model of the ISA_C=0 instance: m_since counts cycles since the trigger, 0 when idle
  logic [31:0] m_mepc = '0, m_mcause = '0, m_mtval = '0, m_mscratch = '0, m_tgt = '0;
  int m_since = 0;
  bit m_on = 1'b0;

  always @(posedge clk) begin
    logic [31:0] old_mepc;
    bit go_exc, go_mret;
    if (rst) begin
      m_mepc = '0; m_mcause = '0; m_mtval = '0; m_mscratch = '0; m_tgt = '0;
      m_since = 0; m_on = 1'b1;
    end else begin
      old_mepc = m_mepc;
      go_exc  = (m_since == 0) && exc_valid;
      go_mret = (m_since == 0) && !exc_valid && mret;
      if (csr_we) begin
        if (csr_addr == 12'h340) m_mscratch = csr_wdata;
        if (csr_addr == 12'h341) m_mepc = csr_wdata & ~32'd3;
        if (csr_addr == 12'h342) m_mcause = csr_wdata & 32'h8000_001F;
        if (csr_addr == 12'h343) m_mtval = csr_wdata;
      end
      if (go_exc) begin
        m_mepc = exc_pc & ~32'd3;
        m_mcause = {27'b0, exc_cause};
        m_mtval = exc_tval;
        m_tgt = mtvec & ~32'd3;
      end
      if (go_mret) m_tgt = old_mepc;
      if (go_exc || go_mret) m_since = 1;
      else if (m_since >= 2 && ready) m_since = 0;
      else if (m_since >= 1) m_since++;
    end
  end

  function automatic logic [31:0] m_rd(input logic [11:0] a);
    return a == 12'h340 ? m_mscratch : a == 12'h341 ? m_mepc :
           a == 12'h342 ? m_mcause : a == 12'h343 ? m_mtval : 32'd0;
  endfunction

  always @(negedge clk) begin
    if (m_on) begin
      chk("flush", {31'b0, flush0}, {31'b0, m_since == 1});
      chk("redirect_valid", {31'b0, rv0}, {31'b0, m_since >= 2});
      chk("busy", {31'b0, busy0}, {31'b0, m_since >= 1});
      chk("csr_hit", {31'b0, hit0}, {31'b0, csr_addr >= 12'h340 && csr_addr <= 12'h343});
      chk("csr_rdata", rdata0, m_rd(csr_addr));
      if (m_since >= 2) chk("redirect_pc", pc0, m_tgt);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a, input string nm, input logic [31:0] e);
    csr_addr = a;
    #1;
    chk(nm, rdata0, e);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_we = 1'b1; csr_addr = a; csr_wdata = d;
    tick();
    csr_we = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    rd(12'h341, "rst_mepc", 32'h0);     chk("rst_hit_mepc", {31'b0, hit0}, 32'd1);
    rd(12'h342, "rst_mcause", 32'h0);   chk("rst_hit_mcause", {31'b0, hit0}, 32'd1);
    rd(12'h343, "rst_mtval", 32'h0);    chk("rst_hit_mtval", {31'b0, hit0}, 32'd1);
    rd(12'h340, "rst_mscratch", 32'h0); chk("rst_hit_mscratch", {31'b0, hit0}, 32'd1);
    rd(12'h300, "rst_other", 32'h0);    chk("rst_hit_other", {31'b0, hit0}, 32'd0);
    chk("rst_pc", pc0, 32'h0);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    tick();
    mtvec = 32'h0000_0101; exc_valid = 1'b1; exc_cause = 5'd2;
    exc_pc = 32'h0000_1236; exc_tval = 32'h0000_00FF;
    tick();
    exc_valid = 1'b0;
    chk("exc_flush_n1", {31'b0, flush0}, 32'd1);
    chk("exc_rv_n1", {31'b0, rv0}, 32'd0);
    rd(12'h341, "exc_mepc_c0", 32'h0000_1234);
    chk("exc_mepc_c1", rdata1, 32'h0000_1236);
    rd(12'h342, "exc_mcause", 32'd2);
    rd(12'h343, "exc_mtval", 32'h0000_00FF);
    tick();
    chk("exc_flush_n2", {31'b0, flush0}, 32'd0);
    chk("exc_rv_n2", {31'b0, rv0}, 32'd1);
    chk("exc_pc_n2", pc0, 32'h0000_0100);
    for (int i = 0; i < 4; i++) begin
      exc_valid = (i == 1); exc_cause = 5'd5;
      tick();
      exc_valid = 1'b0;
      chk("hold_rv", {31'b0, rv0}, 32'd1);
      chk("hold_pc", pc0, 32'h0000_0100);
      chk("hold_busy", {31'b0, busy0}, 32'd1);
    end
    rd(12'h342, "hold_mcause", 32'd2);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("exc_done_busy", {31'b0, busy0}, 32'd0);
    wr(12'h341, 32'h8000_0003);
    rd(12'h341, "wr_mepc", 32'h8000_0000);
    mret = 1'b1;
    tick();
    mret = 1'b0;
    chk("mret_flush", {31'b0, flush0}, 32'd1);
    tick();
    chk("mret_pc", pc0, 32'h8000_0000);
    chk("mret_pc_c1", pc1, 32'h8000_0002);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exc_valid = 1'b1; mret = 1'b1; exc_pc = 32'h0000_2000; exc_cause = 5'd11;
    exc_tval = 32'h0; mtvec = 32'h0000_0201;
    tick();
    exc_valid = 1'b0; mret = 1'b0;
    rd(12'h341, "both_mepc", 32'h0000_2000);
    rd(12'h342, "both_mcause", 32'd11);
    ready = 1'b1;
    tick();
    chk("both_pc", pc0, 32'h0000_0200);
    tick();
    ready = 1'b0;
    chk("min_latency_idle", {31'b0, busy0}, 32'd0);
    wr(12'h342, 32'hFFFF_FFFF);
    rd(12'h342, "warl_mcause", 32'h8000_001F);
    wr(12'h340, 32'hDEAD_BEEF);
    wr(12'h343, 32'h1234_5678);
    rd(12'h340, "wr_mscratch", 32'hDEAD_BEEF);
    rd(12'h343, "wr_mtval", 32'h1234_5678);
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_4000; mret = 1'b1;
    tick();
    csr_we = 1'b0; mret = 1'b0;
    rd(12'h341, "mret_wr_mepc", 32'h0000_4000);
    tick();
    tick();
    chk("mret_wr_pc", pc0, 32'h0000_2000);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exc_valid = 1'b1; exc_pc = 32'h0000_3008; exc_cause = 5'd7;
    csr_we = 1'b1; csr_addr = 12'h341; csr_wdata = 32'h0000_5000;
    tick();
    exc_valid = 1'b0; csr_we = 1'b0;
    rd(12'h341, "collide_mepc", 32'h0000_3008);
    tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;
    exc_valid = 1'b1; exc_pc = 32'h0000_0044; exc_cause = 5'd4;
    exc_tval = 32'h0000_00AA; mtvec = 32'h0000_1000;
    tick();
    exc_valid = 1'b0;
    tick();
    chk("pre_rst_rv", {31'b0, rv0}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("jump_rst_rv", {31'b0, rv0}, 32'd0);
    chk("jump_rst_busy", {31'b0, busy0}, 32'd0);
    chk("jump_rst_pc", pc0, 32'h0);
    rd(12'h340, "jump_rst_mscratch", 32'h0);
    rd(12'h341, "jump_rst_mepc", 32'h0);
    rd(12'h342, "jump_rst_mcause", 32'h0);
    rd(12'h343, "jump_rst_mtval", 32'h0);
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
